// File: rtl/bram_chunk_drain_if.sv
// AXI4-Stream beat channel carrying one packed D2Q9 cell per beat.
interface bram_chunk_drain_if #(
  parameter int unsigned BEAT_W = 144
);
  logic [BEAT_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bram_chunk_drain.sv
// Drains a chunk of cells from the nine D2Q9 direction BRAMs (read in
// lock-step) and streams one packed cell per beat on an AXI4-Stream master.
// Optional build macro DRAIN_CHECKSUM_EN appends an XOR checksum beat.
module bram_chunk_drain #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_DIR = 9
) (
  input  logic                        m00_axis_aclk,
  input  logic                        m00_axis_aresetn,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [ADDR_W:0]             cell_count,
  output logic                        busy,
  output logic                        done,
  output logic                        bram_rd_en,
  output logic [ADDR_W-1:0]           bram_addr,
  input  logic [NUM_DIR*DATA_W-1:0]   bram_rdata,
  bram_chunk_drain_if.master          m00_axis
);

  localparam int unsigned BEAT_W = NUM_DIR * DATA_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   accept_cnt_q, accept_cnt_d;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [BEAT_W-1:0]  head_q, head_d;
  logic [BEAT_W-1:0]  tail_q, tail_d;

`ifdef DRAIN_CHECKSUM_EN
  logic [BEAT_W-1:0]  csum_q, csum_d;
  logic               csum_sent_q, csum_sent_d;
`endif

  logic               tvalid_c;
  logic               pop_c;
  logic               room_c;
  logic               issue_c;
  logic               push_c;
  logic [BEAT_W-1:0]  push_data_c;

  // Handshake and read-credit terms; a read is allowed only if its data is
  // guaranteed a FIFO slot when it lands two cycles later.
  assign tvalid_c = (fifo_cnt_q != 2'd0);
  assign pop_c    = tvalid_c && m00_axis.tready;
  assign room_c   = (fifo_cnt_q + 2'(rvalid_q) - 2'(pop_c)) < 2'd2;
  assign issue_c  = (state_q == S_READ) && (issue_cnt_q != '0) && room_c;

  // State register.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef DRAIN_CHECKSUM_EN
          state_d = (cell_count == '0) ? S_DRAIN : S_READ;
`else
          state_d = (cell_count == '0) ? S_DONE : S_READ;
`endif
        end
      end
      S_READ: begin
        if (issue_cnt_d == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept_cnt_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers: read pointer, counters, read pipeline, skid FIFO.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      ptr_q        <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      rvalid_q     <= 1'b0;
      fifo_cnt_q   <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
`ifdef DRAIN_CHECKSUM_EN
      csum_q       <= '0;
      csum_sent_q  <= 1'b0;
`endif
    end else begin
      ptr_q        <= ptr_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      rvalid_q     <= rvalid_d;
      fifo_cnt_q   <= fifo_cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
`ifdef DRAIN_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_sent_q  <= csum_sent_d;
`endif
    end
  end

  // Datapath next-values: chunk launch, read issue, FIFO push/pop.
  always_comb begin
    ptr_d        = ptr_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    rvalid_d     = issue_c;
    fifo_cnt_d   = fifo_cnt_q;
    head_d       = head_q;
    tail_d       = tail_q;
    push_c       = rvalid_q;
    push_data_c  = bram_rdata;
`ifdef DRAIN_CHECKSUM_EN
    csum_d       = csum_q;
    csum_sent_d  = csum_sent_q;
`endif

    if ((state_q == S_IDLE) && start) begin
      ptr_d        = base_addr;
      issue_cnt_d  = cell_count;
`ifdef DRAIN_CHECKSUM_EN
      accept_cnt_d = cell_count + CNT_W'(1);
      csum_d       = '0;
      csum_sent_d  = 1'b0;
`else
      accept_cnt_d = cell_count;
`endif
    end

    if (issue_c) begin
      ptr_d       = ptr_q + ADDR_W'(1);
      issue_cnt_d = issue_cnt_q - CNT_W'(1);
    end

`ifdef DRAIN_CHECKSUM_EN
    // Fold every data beat into the checksum as it enters the FIFO, and
    // push the checksum once all data has landed and a slot is free.
    if (rvalid_q) begin
      csum_d = csum_q ^ bram_rdata;
    end
    if ((state_q == S_DRAIN) && !csum_sent_q && !rvalid_q &&
        (issue_cnt_q == '0) && ((fifo_cnt_q != 2'd2) || pop_c)) begin
      push_c      = 1'b1;
      push_data_c = csum_q;
      csum_sent_d = 1'b1;
    end
`endif

    if (pop_c) begin
      accept_cnt_d = accept_cnt_q - CNT_W'(1);
    end

    unique case (fifo_cnt_q)
      2'd0: begin
        if (push_c) begin
          head_d     = push_data_c;
          fifo_cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push_c && pop_c) begin
          head_d = push_data_c;
        end else if (pop_c) begin
          fifo_cnt_d = 2'd0;
        end else if (push_c) begin
          tail_d     = push_data_c;
          fifo_cnt_d = 2'd2;
        end
      end
      2'd2: begin
        if (pop_c) begin
          head_d = tail_q;
          if (push_c) begin
            tail_d = push_data_c;
          end else begin
            fifo_cnt_d = 2'd1;
          end
        end
      end
      default: begin
        fifo_cnt_d = 2'd0;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    busy            = (state_q == S_READ) || (state_q == S_DRAIN);
    done            = (state_q == S_DONE);
    bram_rd_en      = issue_c;
    bram_addr       = ptr_q;
    m00_axis.tvalid = tvalid_c;
    m00_axis.tdata  = head_q;
    m00_axis.tlast  = tvalid_c && (accept_cnt_q == CNT_W'(1));
  end

endmodule

// File: tb/tb_bram_chunk_drain.sv
// Directed bench for bram_chunk_drain with a 1-cycle-latency BRAM model.
module tb_bram_chunk_drain;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NUM_DIR = 9;
  localparam int unsigned BEAT_W  = NUM_DIR * DATA_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
`ifdef DRAIN_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  base_addr = '0;
  logic [CNT_W-1:0]   cell_count = '0;
  logic               busy, done, bram_rd_en;
  logic [ADDR_W-1:0]  bram_addr;
  logic [BEAT_W-1:0]  bram_rdata = '0;
  logic [BEAT_W-1:0]  mem [DEPTH];

  bram_chunk_drain_if #(.BEAT_W(BEAT_W)) axis_if ();

  bram_chunk_drain #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_DIR (NUM_DIR)
  ) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .start            (start),
    .base_addr        (base_addr),
    .cell_count       (cell_count),
    .busy             (busy),
    .done             (done),
    .bram_rd_en       (bram_rd_en),
    .bram_addr        (bram_addr),
    .bram_rdata       (bram_rdata),
    .m00_axis         (axis_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: data for the strobed address appears one cycle later.
  always @(posedge clk) if (bram_rd_en) bram_rdata <= mem[bram_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [BEAT_W-1:0] obs,
                     input logic [BEAT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] beat_of(input logic [ADDR_W-1:0] a);
    logic [BEAT_W-1:0] b;
    b = '0;
    for (int d = 0; d < int'(NUM_DIR); d++) b[d*DATA_W +: DATA_W] = {4'(d), a};
    return b;
  endfunction

  // Monitor: logs reads and accepted beats, checks AXIS hold and credit limit.
  logic [BEAT_W-1:0] beat_log[$];
  logic              last_log[$];
  int                acc_cyc_log[$];
  logic [ADDR_W-1:0] addr_log[$];
  int                rd_cyc_log[$];
  int                occ = 0;
  logic              prev_stall = 1'b0;
  logic [BEAT_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_tvalid", axis_if.tvalid, 1);
        chk("hold_tdata", axis_if.tdata, prev_data);
        chk("hold_tlast", axis_if.tlast, prev_last);
      end
      if (bram_rd_en) begin
        addr_log.push_back(bram_addr);
        rd_cyc_log.push_back(cyc);
        occ++;
      end
      if (axis_if.tvalid && axis_if.tready) begin
        beat_log.push_back(axis_if.tdata);
        last_log.push_back(axis_if.tlast);
        acc_cyc_log.push_back(cyc);
        occ--;
      end
      if (bram_rd_en) chk("credit_le2", occ <= 2, 1);
      prev_stall = axis_if.tvalid && !axis_if.tready;
      prev_data  = axis_if.tdata;
      prev_last  = axis_if.tlast;
    end
  end

  // One complete drain: launch, run until done (bounded), then check logs.
  task automatic run_drain(input logic [ADDR_W-1:0] base, input int n,
                           input bit toggle, input string tag);
    int b0, a0, t0, k, nb;
    logic [ADDR_W-1:0] a;
    logic [BEAT_W-1:0] cs, exp;
    b0 = beat_log.size();
    a0 = addr_log.size();
    nb = n + CS;
    axis_if.tready = 1'b1;
    start = 1'b1; base_addr = base; cell_count = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    if (nb > 0) chk({tag, "_busy"}, busy, 1);
    else        chk({tag, "_done_now"}, done, 1);
    k = 0;
    while (!done && k < 200) begin
      axis_if.tready = toggle ? (((k % 4) == 0) || ((k % 4) == 3)) : 1'b1;
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_timeout"}, k < 200, 1);
    axis_if.tready = 1'b1;
    chk({tag, "_nbeats"}, beat_log.size() - b0, nb);
    chk({tag, "_nreads"}, addr_log.size() - a0, n);
    cs = '0;
    for (int i = 0; i < nb && (b0 + i) < beat_log.size(); i++) begin
      a = base + ADDR_W'(i);
      if (i < n) begin
        exp = mem[a];
        cs  = cs ^ exp;
        if ((a0 + i) < addr_log.size()) chk({tag, "_addr"}, addr_log[a0+i], a);
      end else begin
        exp = cs;
      end
      chk({tag, "_tdata"}, beat_log[b0+i], exp);
      chk({tag, "_tlast"}, last_log[b0+i], i == nb - 1);
      if (!toggle) begin
        chk({tag, "_beat_cyc"}, acc_cyc_log[b0+i], t0 + 2 + i);
        if (i < n && (a0 + i) < addr_log.size())
          chk({tag, "_rd_cyc"}, rd_cyc_log[a0+i], t0 + i);
      end
    end
    if (nb > 0 && beat_log.size() > b0)
      chk({tag, "_done_cyc"}, cyc, acc_cyc_log[beat_log.size()-1] + 1);
    else
      chk({tag, "_done_cyc"}, cyc, t0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int b0, k;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = beat_of(ADDR_W'(i));
    mem[12'h400] = BEAT_W'(1);
    mem[12'h401] = BEAT_W'(2);
    mem[12'h402] = BEAT_W'(4);
    axis_if.tready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", bram_rd_en, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_tvalid", axis_if.tvalid, 0);
    chk("rst_tlast", axis_if.tlast, 0);
    chk("rst_tdata", axis_if.tdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_drain(12'h000, 4, 1'b0, "basic");
    run_drain(12'hFFE, 4, 1'b0, "wrap");
    run_drain(12'h100, 8, 1'b1, "stall");
    run_drain(12'h555, 1, 1'b0, "single");
    run_drain(12'h000, 0, 1'b0, "empty");

    // Start while busy must not disturb the running drain.
    start = 1'b1; base_addr = 12'h020; cell_count = CNT_W'(3);
    @(posedge clk); #1;
    base_addr = 12'h900; cell_count = CNT_W'(7);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin @(posedge clk); #1; k++; end
    chk("busy_start_timeout", k < 100, 1);
    chk("busy_start_last_addr", addr_log[addr_log.size()-1], 12'h022);
    chk("busy_start_last_beat", beat_log[beat_log.size()-1 - CS], mem[12'h022]);
    @(posedge clk); #1;

    // Reset in the middle of a 10-cell drain.
    b0 = beat_log.size();
    start = 1'b1; base_addr = 12'h200; cell_count = CNT_W'(10);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while ((beat_log.size() - b0) < 3 && k < 50) begin @(posedge clk); #1; k++; end
    chk("mid_rst_3beats", beat_log.size() - b0, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", bram_rd_en, 0);
    chk("mid_rst_addr", bram_addr, 0);
    chk("mid_rst_tvalid", axis_if.tvalid, 0);
    chk("mid_rst_tlast", axis_if.tlast, 0);
    chk("mid_rst_tdata", axis_if.tdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_tvalid", axis_if.tvalid, 0);
    run_drain(12'h300, 2, 1'b0, "post_rst");

    // Checksum data pattern 1, 2, 4.
    b0 = beat_log.size();
    run_drain(12'h400, 3, 1'b0, "csum");
`ifdef DRAIN_CHECKSUM_EN
    chk("csum_value", beat_log[b0+3], BEAT_W'(7));
    chk("csum_last", last_log[b0+3], 1);
    chk("csum_data_notlast", last_log[b0+2], 0);
`else
    chk("nocsum_last_data", beat_log[b0+2], BEAT_W'(4));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
